// File: rtl/lfsr_prbs_burst_ctrl_pkg.sv
// Shared definitions for the PRBS burst controller: FSM state encoding and
// burst counter width.
package lfsr_prbs_burst_defs;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned BURST_COUNT_WIDTH = 16;

endpackage

// File: rtl/lfsr_prbs_burst_ctrl_if.sv
// Command handshake plus AXI-stream-style output of the PRBS burst controller.
// master = command issuer / stream sink, slave = the burst controller.
interface lfsr_prbs_burst_ctrl_if #(
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  cmd_restart;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   modport master (
      output cmd_len, cmd_restart, cmd_valid, m_axis_tready,
      input  cmd_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   modport slave (
      input  cmd_len, cmd_restart, cmd_valid, m_axis_tready,
      output cmd_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

endinterface

// File: rtl/lfsr_prbs_burst_ctrl_gen.sv
// lfsr_prbs_gen: word-wide PRBS generator. data_out is the next OUTPUT_WIDTH
// bits of the sequence; enable advances the state by one word.
module lfsr_prbs_gen #(
   parameter int unsigned           LFSR_WIDTH   = 9,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = LFSR_WIDTH'(9'h021),
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = '1,
   parameter string                 LFSR_CONFIG  = "FIBONACCI",
   parameter bit                    REVERSE      = 1'b0,
   parameter int unsigned           OUTPUT_WIDTH = 8,
   parameter string                 STYLE        = "AUTO"
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   output logic [OUTPUT_WIDTH-1:0] data_out
);

   localparam bit                    GALOIS   = (LFSR_CONFIG == "GALOIS");
   // Fibonacci taps: MSB is x^W, POLY[W-1:1] select the remaining taps.
   localparam logic [LFSR_WIDTH-1:0] TAP_MASK = {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]};

   if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
      $error("lfsr_prbs_gen: unsupported STYLE");
   end
   if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : g_bad_cfg
      $error("lfsr_prbs_gen: unsupported LFSR_CONFIG");
   end

   logic [LFSR_WIDTH-1:0]   state_q;
   logic [LFSR_WIDTH-1:0]   state_d;
   logic [LFSR_WIDTH-1:0]   s;
   logic [OUTPUT_WIDTH-1:0] word;
   logic                    b;

   always_comb begin
      s    = state_q;
      word = '0;
      b    = 1'b0;
      for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
         if (GALOIS) begin
            b = s[LFSR_WIDTH-1];
            s = {s[LFSR_WIDTH-2:0], 1'b0} ^ (b ? LFSR_POLY : '0);
         end else begin
            b = ^(s & TAP_MASK);
            s = {s[LFSR_WIDTH-2:0], b};
         end
         if (REVERSE) word = {b, word[OUTPUT_WIDTH-1:1]};
         else         word = {word[OUTPUT_WIDTH-2:0], b};
      end
      state_d  = s;
      data_out = word;
   end

   always_ff @(posedge clk) begin
      if (rst)         state_q <= LFSR_INIT;
      else if (enable) state_q <= state_d;
   end

endmodule

// File: rtl/lfsr_prbs_burst_ctrl.sv
// Burst controller streaming lfsr_prbs_gen words with valid/ready and tlast.
// Optional single-bit error injection: define LFSR_PRBS_BURST_ERR_INJ_EN.
module lfsr_prbs_burst_ctrl
   import lfsr_prbs_burst_defs::*;
#(
   parameter int unsigned           LFSR_WIDTH  = 9,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(9'h021),
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
   parameter string                 LFSR_CONFIG = "FIBONACCI",
   parameter bit                    REVERSE     = 1'b0,
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter string                 STYLE       = "AUTO",
   parameter int unsigned           LEN_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   lfsr_prbs_burst_ctrl_if.slave        bus,
   input  logic                         abort,
   input  logic                         err_inject,
   output logic                         busy,
   output logic [BURST_COUNT_WIDTH-1:0] burst_count
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);

   state_e                       state_q;
   logic [LEN_WIDTH-1:0]         remaining_q;
   logic                         tlast_q;
   logic [BURST_COUNT_WIDTH-1:0] burst_count_q;
   logic [DATA_WIDTH-1:0]        gen_data;
   logic                         accept;
   logic                         xfer;
   logic                         gen_rst;

   assign accept  = (state_q == ST_IDLE) && bus.cmd_valid;
   assign xfer    = (state_q == ST_RUN) && bus.m_axis_tready;
   assign gen_rst = rst || (accept && bus.cmd_restart);

   lfsr_prbs_gen #(
      .LFSR_WIDTH  (LFSR_WIDTH),
      .LFSR_POLY   (LFSR_POLY),
      .LFSR_INIT   (LFSR_INIT),
      .LFSR_CONFIG (LFSR_CONFIG),
      .REVERSE     (REVERSE),
      .OUTPUT_WIDTH(DATA_WIDTH),
      .STYLE       (STYLE)
   ) u_gen (
      .clk     (clk),
      .rst     (gen_rst),
      .enable  (xfer),
      .data_out(gen_data)
   );

   // tlast is tracked as its own register, anticipating remaining reaching 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         remaining_q   <= '0;
         tlast_q       <= 1'b0;
         burst_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  remaining_q <= bus.cmd_len;
                  tlast_q     <= (bus.cmd_len == LEN_ONE);
                  if (bus.cmd_len != '0) state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  remaining_q <= remaining_q - LEN_ONE;
                  tlast_q     <= (remaining_q == LEN_TWO);
               end
               if (xfer && tlast_q) begin
                  state_q       <= ST_IDLE;
                  tlast_q       <= 1'b0;
                  burst_count_q <= burst_count_q + 1'b1;
               end else if (abort) begin
                  state_q <= ST_IDLE;
                  tlast_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = (state_q == ST_IDLE);
   assign bus.m_axis_tvalid = (state_q == ST_RUN);
   assign bus.m_axis_tlast  = tlast_q;
   assign busy              = (state_q == ST_RUN);
   assign burst_count       = burst_count_q;

`ifdef LFSR_PRBS_BURST_ERR_INJ_EN
   logic err_pend_q;

   // The flip is applied only at the output; the generator never sees it.
   always_ff @(posedge clk) begin
      if (rst)                    err_pend_q <= 1'b0;
      else if (xfer && err_pend_q) err_pend_q <= 1'b0;
      else if (err_inject)        err_pend_q <= 1'b1;
   end

   assign bus.m_axis_tdata = gen_data ^ {{(DATA_WIDTH-1){1'b0}}, err_pend_q};
`else
   logic unused_err_inject;
   assign unused_err_inject = err_inject;
   assign bus.m_axis_tdata  = gen_data;
`endif

endmodule

// File: tb/tb_lfsr_prbs_burst_ctrl.sv
// Directed bench for lfsr_prbs_burst_ctrl against a bit-serial PRBS9 model.
module tb_lfsr_prbs_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic        err_inject;
   logic        busy;
   logic [15:0] burst_count;

   int          n_chk   = 0;
   int          n_pass  = 0;
   int          ptr     = 0;
   int          biterrs = 0;
   logic [7:0]  model_w [0:31];

   lfsr_prbs_burst_ctrl_if #(.LEN_WIDTH(16), .DATA_WIDTH(8)) bus ();

   lfsr_prbs_burst_ctrl #(
      .LFSR_WIDTH (9),
      .LFSR_POLY  (9'h021),
      .LFSR_INIT  (9'h1FF),
      .LFSR_CONFIG("FIBONACCI"),
      .REVERSE    (1'b0),
      .DATA_WIDTH (8),
      .STYLE      ("AUTO"),
      .LEN_WIDTH  (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .abort      (abort),
      .err_inject (err_inject),
      .busy       (busy),
      .burst_count(burst_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int len, input logic restart);
      bus.cmd_len     = 16'(len);
      bus.cmd_restart = restart;
      bus.cmd_valid   = 1'b1;
      check("cmd_ready_at_cmd", 32'(bus.cmd_ready), 1);
      cyc();
      bus.cmd_valid   = 1'b0;
      bus.cmd_restart = 1'b0;
      if (restart) ptr = 0;
   endtask

   // Collect n words of a burst of total length, tready following pat[].
   task automatic collect(input string tag, input int n, input int total,
                          input logic [15:0] pat, input int plen, input int flip_at);
      int         got  = 0;
      int         cycn = 0;
      logic       rdy;
      logic [7:0] exp_d;
      while (got < n && cycn < 64) begin
         rdy = pat[cycn % plen];
         bus.m_axis_tready = rdy;
         exp_d = model_w[ptr] ^ ((got == flip_at) ? 8'h01 : 8'h00);
         check({tag, "_tvalid"}, 32'(bus.m_axis_tvalid), 1);
         check({tag, "_busy"}, 32'(busy), 1);
         check({tag, "_tdata"}, 32'(bus.m_axis_tdata), 32'(exp_d));
         check({tag, "_tlast"}, 32'(bus.m_axis_tlast), 32'(got == total - 1));
         if (bus.m_axis_tvalid && rdy) begin
            biterrs += $countones(bus.m_axis_tdata ^ model_w[ptr]);
            got++;
            ptr++;
         end
         cyc();
         cycn++;
      end
      bus.m_axis_tready = 1'b0;
      check({tag, "_nwords"}, 32'(got), 32'(n));
   endtask

   task automatic check_idle(input string tag, input int bc);
      check({tag, "_idle_tvalid"}, 32'(bus.m_axis_tvalid), 0);
      check({tag, "_idle_ready"}, 32'(bus.cmd_ready), 1);
      check({tag, "_idle_tlast"}, 32'(bus.m_axis_tlast), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_burst_count"}, 32'(burst_count), 32'(bc));
   endtask

   initial begin
      logic bits [0:264];
      for (int i = 0; i < 9; i++) bits[i] = 1'b1;
      for (int i = 9; i < 265; i++) bits[i] = bits[i-9] ^ bits[i-5];
      for (int w = 0; w < 32; w++) begin
         model_w[w] = '0;
         for (int k = 0; k < 8; k++) model_w[w] = {model_w[w][6:0], bits[9 + 8*w + k]};
      end

      rst = 1'b1; abort = 1'b0; err_inject = 1'b0;
      bus.cmd_len = '0; bus.cmd_restart = 1'b0; bus.cmd_valid = 1'b0; bus.m_axis_tready = 1'b0;
      cyc(); cyc();
      check_idle("reset", 0);
      check("reset_tdata", 32'(bus.m_axis_tdata), 32'(model_w[0]));
      rst = 1'b0;
      cyc();

      // Single burst with restart
      send_cmd(5, 1'b1);
      collect("single", 5, 5, 16'hFFFF, 1, -1);
      check_idle("single", 1);

      // Backpressure: tready 1,0,0,1,1,0,1
      send_cmd(4, 1'b1);
      collect("bp", 4, 4, 16'b1011001, 7, -1);
      check_idle("bp", 2);

      // Continuity across bursts, one idle cycle between them
      send_cmd(3, 1'b1);
      collect("cont_a", 3, 3, 16'hFFFF, 1, -1);
      check_idle("cont_a", 3);
      send_cmd(3, 1'b0);
      collect("cont_b", 3, 3, 16'hFFFF, 1, -1);
      check("cont_ptr", 32'(ptr), 6);
      check_idle("cont_b", 4);

      // Zero length: consumed, nothing emitted
      send_cmd(0, 1'b0);
      check_idle("zero_a", 4);
      cyc();
      check_idle("zero_b", 4);

      // Abort after 4 of 10 words, then continue from word 4
      send_cmd(10, 1'b1);
      collect("abort", 4, 10, 16'hFFFF, 1, -1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_idle("abort", 4);
      check("abort_ptr", 32'(ptr), 4);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_idle("abort_idle", 4);
      send_cmd(2, 1'b0);
      collect("after_abort", 2, 2, 16'hFFFF, 1, -1);
      check_idle("after_abort", 5);

      // Abort together with the final transfer completes the burst
      send_cmd(2, 1'b1);
      collect("abort_last_a", 1, 2, 16'hFFFF, 1, -1);
      abort = 1'b1;
      bus.m_axis_tready = 1'b1;
      check("abort_last_tlast", 32'(bus.m_axis_tlast), 1);
      check("abort_last_tdata", 32'(bus.m_axis_tdata), 32'(model_w[1]));
      cyc();
      abort = 1'b0;
      bus.m_axis_tready = 1'b0;
      check_idle("abort_last", 6);

      // Mid-burst reset
      send_cmd(8, 1'b1);
      collect("midrst", 2, 8, 16'hFFFF, 1, -1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ptr = 0;
      check_idle("midrst", 0);
      send_cmd(2, 1'b0);
      collect("post_rst", 2, 2, 16'hFFFF, 1, -1);
      check_idle("post_rst", 1);

`ifdef LFSR_PRBS_BURST_ERR_INJ_EN
      // Two pulses under backpressure yield one flipped word
      biterrs = 0;
      send_cmd(4, 1'b1);
      err_inject = 1'b1;
      cyc();
      cyc();
      err_inject = 1'b0;
      check("errinj_held_tdata", 32'(bus.m_axis_tdata), 32'(model_w[0] ^ 8'h01));
      collect("errinj", 4, 4, 16'hFFFF, 1, 0);
      check("errinj_biterrs", 32'(biterrs), 1);
      check_idle("errinj", 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
